// File: rtl/filterbank_window_seq_pkg.sv
// Shared constants, state encoding and saturation helper for the window sequencer.
package filterbank_window_seq_pkg;

  localparam int TAPS        = 16;
  localparam int SAMPLES     = 32;
  localparam int V_RING      = 1024;
  localparam int SLOT_STRIDE = 64;

  localparam int TAP_W  = $clog2(TAPS);
  localparam int SAMP_W = $clog2(SAMPLES);
  localparam int V_AW   = $clog2(V_RING);

  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMPLES - 1);

  // state    | meaning
  // ST_IDLE  | waiting for start
  // ST_RUN   | issuing one tap per cycle
  // ST_HOLD  | at a sample boundary with no output credit; no reads
  // ST_DRAIN | all taps issued; waiting for pipeline, FIFO and pops
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fb_state_e;

  // Clamp a signed value to the range of a w-bit signed integer.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fb_pcm_fifo2.sv
// Two-entry synchronous FIFO for output PCM; count feeds the credit logic.
module fb_pcm_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign valid   = (count != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/filterbank_window_seq.sv
// Synthesis-window sequencer: walks D ROM and V ring, 16-tap MAC per sample,
// saturates and queues 16-bit PCM behind a credit-limited 2-entry FIFO.
module filterbank_window_seq #(
  parameter int COEF_W = 18,
  parameter int V_W    = 18,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 18,
  parameter int PCM_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               v_slot,
  output logic                     busy,
  output logic                     done,
  output logic                     rom_en,
  output logic [8:0]               rom_addr,
  input  logic signed [COEF_W-1:0] rom_data,
  output logic                     v_rd_en,
  output logic [9:0]               v_addr,
  input  logic signed [V_W-1:0]    v_data,
  output logic                     pcm_valid,
  input  logic                     pcm_ready,
  output logic signed [PCM_W-1:0]  pcm_data
);
  import filterbank_window_seq_pkg::*;

  localparam int PW = COEF_W + V_W;

  fb_state_e state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [SAMP_W-1:0] samp_q, samp_d;
  logic [3:0]        v_slot_q;
  logic              issue;
  logic              credit_ok;
  logic [1:0]        inflight_q;
  logic [1:0]        fifo_count;
  logic [SAMP_W:0]   pops_q;
  logic              pcm_pop;

  logic                    s1_vld_q, s1_first_q, s1_last_q;
  logic                    p_vld_q, p_first_q, p_last_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic                    acc_done_q;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [63:0]      sat64;
  logic                    unused_sat;

  // A sample may only begin if it is guaranteed a FIFO slot on completion.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < 3'd2;
  assign pcm_pop   = pcm_valid && pcm_ready;

  assign busy     = (state_q != ST_IDLE);
  assign rom_en   = issue;
  assign v_rd_en  = issue;
  assign rom_addr = {tap_q, samp_q};
  // Ring wrap is the natural 10-bit overflow of this sum.
  assign v_addr   = {v_slot_q, 6'b0} + {tap_q[3:1], 7'b0} + (tap_q[0] ? 10'd96 : 10'd0)
                  + {5'b0, samp_q};

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tap_q    <= '0;
      samp_q   <= '0;
      v_slot_q <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      samp_q  <= samp_d;
      if (state_q == ST_IDLE && start) v_slot_q <= v_slot;
    end
  end

  // Next-state, tap issue and done decode.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    samp_d  = samp_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          tap_d   = '0;
          samp_d  = '0;
        end
      end
      ST_RUN: begin
        if (tap_q == '0 && !credit_ok) begin
          state_d = ST_HOLD;
        end else begin
          issue = 1'b1;
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            if (samp_q == SAMP_LAST) state_d = ST_DRAIN;
            else                     samp_d  = samp_q + 1'b1;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (credit_ok) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (inflight_q == 2'd0 && fifo_count == 2'd0 && pops_q == (SAMP_W+1)'(SAMPLES)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Samples in flight (started, not yet pushed) and pops within the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 2'd0;
      pops_q     <= '0;
    end else begin
      case ({issue && (tap_q == '0), acc_done_q})
        2'b10:   inflight_q <= inflight_q + 2'd1;
        2'b01:   inflight_q <= inflight_q - 2'd1;
        default: inflight_q <= inflight_q;
      endcase
      if (state_q == ST_IDLE && start) pops_q <= '0;
      else if (pcm_pop)                pops_q <= pops_q + 1'b1;
    end
  end

  assign prod_ext = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

  // Read-data stage, product register, accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      p_vld_q    <= 1'b0;
      p_first_q  <= 1'b0;
      p_last_q   <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      acc_done_q <= 1'b0;
    end else begin
      s1_vld_q   <= issue;
      s1_first_q <= (tap_q == '0);
      s1_last_q  <= (tap_q == TAP_LAST);
      p_vld_q    <= s1_vld_q;
      p_first_q  <= s1_first_q;
      p_last_q   <= s1_last_q;
      if (s1_vld_q) prod_q <= rom_data * v_data;
      if (p_vld_q)  acc_q  <= p_first_q ? prod_ext : acc_q + prod_ext;
      acc_done_q <= p_vld_q && p_last_q;
    end
  end

  assign acc_sh     = acc_q >>> SHIFT;
  assign sat64      = sat_clamp({{(64-ACC_W){acc_sh[ACC_W-1]}}, acc_sh}, PCM_W);
  assign unused_sat = ^sat64[63:PCM_W];

  fb_pcm_fifo2 #(.W(PCM_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (acc_done_q),
    .din   (sat64[PCM_W-1:0]),
    .pop   (pcm_pop),
    .dout  (pcm_data),
    .valid (pcm_valid),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_filterbank_window_seq.sv
// Directed bench for filterbank_window_seq: address tables, arithmetic vectors,
// backpressure, random ready over back-to-back blocks, mid-block reset.
module tb_filterbank_window_seq;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [3:0]         v_slot;
  logic               busy, done, rom_en, v_rd_en, pcm_valid, pcm_ready;
  logic [8:0]         rom_addr;
  logic [9:0]         v_addr;
  logic signed [17:0] rom_data, v_data;
  logic signed [15:0] pcm_data;

  always #5 clk = ~clk;

  filterbank_window_seq dut (
    .clk(clk), .reset(reset), .start(start), .v_slot(v_slot), .busy(busy), .done(done),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .v_rd_en(v_rd_en), .v_addr(v_addr), .v_data(v_data),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .pcm_data(pcm_data)
  );

  logic signed [17:0] rom_mem [512];
  logic signed [17:0] vram    [1024];

  always @(posedge clk) begin
    if (rom_en)  rom_data <= rom_mem[rom_addr];
    if (v_rd_en) v_data   <= vram[v_addr];
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int start_cyc, first_rom_cyc, first_val_cyc, last_pop_cyc, done_cnt;
  int ready_mode = 0;  // 0: held high, 1: random, 2: held low
  logic [8:0]         rom_log [$];
  logic [9:0]         v_log   [$];
  logic signed [15:0] got_q   [$];

  // Monitor: drive ready for this cycle, then record what the DUT shows.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       pcm_ready = 1'b1;
      1:       pcm_ready = 1'($urandom_range(0, 1));
      default: pcm_ready = 1'b0;
    endcase
    if (rom_en) begin
      rom_log.push_back(rom_addr);
      v_log.push_back(v_addr);
      if (first_rom_cyc < 0) first_rom_cyc = cyc;
    end
    if (pcm_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (pcm_valid && pcm_ready) begin
      got_q.push_back(pcm_data);
      last_pop_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    logic [3:0] slot;
    int j;
    int i;
    int exp_rom;
    int exp_v;
  } addr_vec_t;

  typedef struct {
    int d;
    int v;
    int exp_pcm;
  } arith_vec_t;

  addr_vec_t  addr_tab [8];
  arith_vec_t arith_tab [3];

  task automatic check(input string name, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int v_model(input int slot, input int j, input int i);
    return (slot * 64 + 128 * (i / 2) + ((i % 2) ? 96 : 0) + j) % 1024;
  endfunction

  function automatic longint model_sample(input int slot, input int j);
    longint acc = 0;
    for (int i = 0; i < 16; i++)
      acc += longint'(rom_mem[j + 32 * i]) * longint'(vram[v_model(slot, j, i)]);
    acc = acc >>> 18;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 512; k++)  rom_mem[k] = 18'(int'($urandom_range(0, 65535)) - 32768);
    for (int k = 0; k < 1024; k++) vram[k]    = 18'(int'($urandom_range(0, 32767)) - 16384);
  endtask

  task automatic launch(input logic [3:0] slot, input int rmode);
    @(negedge clk);
    rom_log.delete(); v_log.delete(); got_q.delete();
    first_rom_cyc = -1; first_val_cyc = -1; last_pop_cyc = -1; done_cnt = 0;
    ready_mode = rmode;
    v_slot = slot;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; optionally pulse start (with another slot) mid-block.
  task automatic wait_done(input int budget, input int poke_at);
    for (int k = 0; k < budget; k++) begin
      if (done_cnt > 0) break;
      start = (k == poke_at);
      if (k == poke_at) v_slot = 4'hA;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_stream(input string name, input int slot);
    check({name, "_count"}, got_q.size(), 32);
    for (int j = 0; j < 32 && j < got_q.size(); j++)
      check($sformatf("%s_s%0d", name, j), longint'(got_q[j]), model_sample(slot, j));
  endtask

  task automatic check_sweep(input string name, input int slot);
    int errs = 0;
    check({name, "_taps"}, rom_log.size(), 512);
    for (int n = 0; n < rom_log.size(); n++)
      if (int'(rom_log[n]) != (n / 16) + 32 * (n % 16) ||
          int'(v_log[n]) != v_model(slot, n / 16, n % 16)) errs++;
    check({name, "_addr_errs"}, errs, 0);
  endtask

  task automatic check_table(input int slot);
    for (int t = 0; t < 8; t++) begin
      if (int'(addr_tab[t].slot) == slot) begin
        int idx = addr_tab[t].j * 16 + addr_tab[t].i;
        if (idx < rom_log.size()) begin
          check($sformatf("tab%0d_rom", t), rom_log[idx], addr_tab[t].exp_rom);
          check($sformatf("tab%0d_v", t), v_log[idx], addr_tab[t].exp_v);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_rom_en"}, rom_en, 0);
    check({name, "_v_rd_en"}, v_rd_en, 0);
    check({name, "_rom_addr"}, rom_addr, 0);
    check({name, "_v_addr"}, v_addr, 0);
    check({name, "_pcm_valid"}, pcm_valid, 0);
    check({name, "_pcm_data"}, pcm_data, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_tab[0] = '{4'd0,  0,  0,   0,   0};
    addr_tab[1] = '{4'd0,  0,  1,  32,  96};
    addr_tab[2] = '{4'd0,  5,  3, 101, 229};
    addr_tab[3] = '{4'd0, 31, 15, 511, 1023};
    addr_tab[4] = '{4'd15, 0,  0,   0, 960};
    addr_tab[5] = '{4'd15, 0,  1,  32,  32};
    addr_tab[6] = '{4'd15, 31, 14, 479, 863};
    addr_tab[7] = '{4'd15, 31, 15, 511, 959};
    arith_tab[0] = '{65536, 1, 4};
    arith_tab[1] = '{131071, 131071, 32767};
    arith_tab[2] = '{131071, -131071, -32768};

    reset = 1'b1; start = 1'b0; v_slot = 4'd0; pcm_ready = 1'b1;
    rom_data = '0; v_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;
    fill_random();

    // Address sweep, slot 0, ready high; latency and throughput.
    launch(4'd0, 0);
    wait_done(2000, -1);
    repeat (4) @(negedge clk);
    check("lat_first_rom", first_rom_cyc - start_cyc, 1);
    check("lat_first_valid", first_val_cyc - start_cyc, 20);
    check("lat_last_pop", last_pop_cyc - start_cyc, 516);
    check_table(0);
    check_sweep("sweep0", 0);
    check_stream("blk0", 0);
    check("blk0_done", done_cnt, 1);

    // Ring wrap, slot 15.
    launch(4'd15, 0);
    wait_done(2000, -1);
    repeat (4) @(negedge clk);
    check_table(15);
    check_sweep("sweep15", 15);
    check_stream("blk15", 15);
    check("blk15_done", done_cnt, 1);

    // Arithmetic and saturation vectors.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 512; k++)  rom_mem[k] = 18'(arith_tab[t].d);
      for (int k = 0; k < 1024; k++) vram[k]    = 18'(arith_tab[t].v);
      launch(4'd0, 0);
      wait_done(2000, -1);
      check($sformatf("arith%0d_count", t), got_q.size(), 32);
      for (int j = 0; j < got_q.size(); j++)
        check($sformatf("arith%0d_s%0d", t, j), longint'(got_q[j]), arith_tab[t].exp_pcm);
    end

    // Backpressure from start: two samples then HOLD.
    fill_random();
    launch(4'd5, 2);
    repeat (150) @(negedge clk);
    check("bp_taps_issued", rom_log.size(), 32);
    check("bp_rom_en_hold", rom_en, 0);
    check("bp_busy", busy, 1);
    check("bp_valid", pcm_valid, 1);
    check("bp_no_pops", got_q.size(), 0);
    ready_mode = 0;
    wait_done(2000, -1);
    repeat (6) @(negedge clk);
    check_stream("bp", 5);
    check("bp_done", done_cnt, 1);

    // Random ready over three back-to-back blocks; a stray start mid-block.
    for (int b = 0; b < 3; b++) begin
      logic [3:0] s;
      s = 4'(3 + 5 * b);
      launch(s, 1);
      wait_done(4000, (b == 1) ? 50 : -1);
      check_stream($sformatf("rnd%0d", b), int'(s));
      check($sformatf("rnd%0d_done", b), done_cnt, 1);
    end

    // Reset at cycle 100 of a block.
    launch(4'd6, 0);
    repeat (98) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    reset = 1'b0;
    done_cnt = 0;
    repeat (600) @(negedge clk);
    check("rst_no_done", done_cnt, 0);
    check("rst_idle", busy, 0);
    launch(4'd6, 1);
    wait_done(4000, 30);
    repeat (4) @(negedge clk);
    check_stream("post_rst", 6);
    check("post_rst_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/filterbank_window_seq.md
Name: filterbank_window_seq

Overview:
Sequences the synthesis-window stage of the polyphase filterbank. For each 32-sample PCM block it walks the 512-entry window coefficient ROM (D table) and the 1024-entry V ring buffer, runs a 16-tap multiply-accumulate per output sample, then saturates the result and hands out 16-bit PCM through a valid/ready port. It sits between the matrixing stage, which writes V, and the PCM output / reorder logic.

Parameters:
COEF_W, 18, D coefficient width; signed; matches the window ROM data width.
V_W, 18, V buffer sample width; signed.
ACC_W, 40, accumulator width; must be ≥ COEF_W+V_W+4.
SHIFT, 18, arithmetic right shift applied to the accumulator before saturation.
PCM_W, 16, output PCM width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to process one block; sampled only in IDLE
v_slot  in  4  ring position of the newest V frame; base address = v_slot*64; captured with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the 32nd sample is accepted
rom_en  out  1  window ROM read enable
rom_addr  out  9  window ROM address
rom_data  in  COEF_W  ROM data, valid 1 cycle after rom_en
v_rd_en  out  1  V RAM read enable
v_addr  out  10  V RAM address
v_data  in  V_W  V data, valid 1 cycle after v_rd_en
pcm_valid  out  1  output FIFO non-empty
pcm_ready  in  1  consumer accepts when valid&&ready
pcm_data  out  PCM_W  head of output FIFO; signed

Behaviour:
- Reset values: busy=0, done=0, rom_en=0, v_rd_en=0, rom_addr=0, v_addr=0, pcm_valid=0, pcm_data=0.
- Reset clears the FSM, counters, pipeline valids, accumulator and FIFO, and is allowed mid-block. Any in-flight block is discarded and no done is produced.
- FSM states:
  - IDLE: on start → RUN. Capture v_slot; j=0, i=0.
  - RUN: each cycle issue one tap (rom_en=v_rd_en=1). i increments. When i=15, i wraps to 0 and j increments. After the tap (j=31, i=15) → DRAIN.
  - HOLD: entered from RUN at a sample boundary (i=0) when credits=0. No reads issued. Returns to RUN when credits>0.
  - DRAIN: wait until the pipeline is empty, the FIFO is empty, and 32 pops have occurred. Then pulse done and → IDLE.
- start is ignored outside IDLE.
- Address rule for tap (j,i) with m=i>>1:
  - rom_addr = j + 32*i.
  - v_addr = (base + 128*m + (i odd ? 96 : 0) + j) mod 1024.
  - The mod-1024 wrap is natural 10-bit overflow.
- Pipeline, for a tap issued at cycle c:
  - Data arrives at c+1.
  - Signed product is registered at c+2.
  - Accumulated at c+3; i=0 loads the accumulator, other taps add.
  - The final sum is written to the FIFO at c+4 after the shift/saturate stage.
- Arithmetic:
  - product = rom_data × v_data, signed, COEF_W+V_W bits, sign-extended to ACC_W.
  - result = acc >>> SHIFT (floor). Clamp to [−2^(PCM_W−1), 2^(PCM_W−1)−1].
- Flow control:
  - The output FIFO holds 2 entries.
  - credits = 2 − (samples in pipeline + FIFO count).
  - A new sample (i=0) issues only when credits>0. Once a sample has started, it always completes, so the FIFO never overflows.
  - Pop and push in the same cycle is allowed.
- Throughput with pcm_ready held high is 16 cycles per sample.
- Latency: start accepted at cycle 0 → first rom_en at cycle 1 → first pcm_valid at cycle 20.

Decomposition:
- Shared filterbank package holds:
  - the tap/sample counts (16, 32);
  - the V ring size 1024 and slot stride 64;
  - the saturate function;
  - the FSM state encoding.
- One sub-module: fb_pcm_fifo2, a 2-entry synchronous FIFO with count output used for the credit calculation.

Test Plan:
- Address sweep: v_slot=0, ready=1. Expected sequence:
  - j=0,i=0 → rom 0, v 0;
  - j=0,i=1 → rom 32, v 96;
  - j=5,i=3 → rom 101, v 229.
  - All 512 pairs are checked against a model.
- Ring wrap: v_slot=15 (base 960):
  - j=0,i=1 → v_addr 32;
  - j=31,i=14 → v_addr (960+896+31) mod 1024 = 863.
- Arithmetic: rom_data=65536, v_data=1 for all taps → every sample = 4. Then rom_data=131071, v_data=131071 → 32767. Then v_data=−131071 → −32768.
- Backpressure: pcm_ready=0 from start.
  - Exactly 2 samples enter the FIFO.
  - rom_en is low in HOLD.
  - Raising ready resumes the stream.
  - 32 values arrive in order and done pulses once.
- Random ready toggling over 3 back-to-back blocks (start issued 1 cycle after each done) → output matches the model, with no dropped or duplicated samples.
- Reset at cycle 100 mid-block → next cycle all outputs are at their reset values. A following start runs a full clean block, and no spurious done appears for the aborted block; start pulsed while busy is ignored.
